relu_ctrl: RTL and testbench
============================

RELU_CTRL -- requirements
Module: relu_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 45, SHALL set the width of one feature-map element.
REQ-002 Parameter MAP_X, default 24, SHALL set the row count per map.
REQ-003 Parameter MAP_Y, default 24, SHALL set the column count per map.
REQ-004 Parameter CHANNELS, default 8, SHALL set the number of maps per pass.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-007 relu_enable  in  1  SHALL request start of one full pass.
REQ-008 relu_hold  in  1  SHALL suspend issue of new reads while high.
REQ-009 rd_en  out  1  SHALL strobe a read of the convolution buffer.
REQ-010 rd_ch/rd_row/rd_col  out  3/5/5  SHALL give the read address.
REQ-011 rd_data  in  DATA_WIDTH  SHALL carry the signed element, valid exactly one cycle after rd_en.
REQ-012 wr_en  out  1  SHALL strobe a write to the result buffer.
REQ-013 wr_ch/wr_row/wr_col  out  3/5/5  SHALL give the write address.
REQ-014 wr_data  out  DATA_WIDTH  SHALL carry the ReLU result.
REQ-015 busy  out  1  SHALL be high in RUN and DRAIN.
REQ-016 relu_done  out  1  SHALL flag a completed pass.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN when relu_enable=1; relu_done SHALL clear on the same edge.
REQ-019 DONE -> RUN when relu_enable=1; otherwise DONE SHALL persist.
REQ-020 relu_enable SHALL be ignored in RUN and DRAIN.
REQ-021 In RUN with relu_hold=0, rd_en SHALL be 1 and the address SHALL advance: col fastest, then row, then channel, from (0,0,0) to (CHANNELS-1,MAP_X-1,MAP_Y-1).
REQ-022 In RUN with relu_hold=1, rd_en SHALL be 0 and the address counters SHALL hold.
REQ-023 The cycle after the read of the last address is issued, the FSM SHALL enter DRAIN.
REQ-024 Pipeline: rd_en at cycle N -> rd_data sampled at N+1 -> wr_en, write address = read address and wr_data at N+2; write order SHALL equal read order.
REQ-025 relu_hold SHALL NOT stall outstanding elements; they SHALL complete per REQ-024.
REQ-026 ReLU: wr_data SHALL be 0 if rd_data[DATA_WIDTH-1]=1, else equal to rd_data.
REQ-027 DRAIN SHALL last exactly 2 cycles (last write issued in its second cycle), then go to DONE.
REQ-028 relu_done SHALL be 1 exactly while in DONE.
REQ-029 A full pass with no hold SHALL issue CHANNELS*MAP_X*MAP_Y reads and the same number of writes (4608 at defaults), with relu_done rising 4611 cycles after the start edge.
REQ-030 wr_en SHALL be 0 whenever no element is in the pipeline's output stage.
REQ-031 Address counters SHALL never exceed MAP_Y-1, MAP_X-1 or CHANNELS-1; wrap from MAP_Y-1 to 0 SHALL carry into row, and from MAP_X-1 to 0 into channel.

Reset
REQ-032 On rst=1, the FSM SHALL go to IDLE asynchronously, counters and pipeline valids SHALL clear, and rd_en, wr_en, busy and relu_done SHALL be 0, with all addresses and wr_data at 0.
REQ-033 A reset mid-pass SHALL discard in-flight elements without further writes; the next start SHALL restart from address (0,0,0).

Verification
REQ-034 Buffer rows 0-11 = 45'h1fedcba98765, rows 12-23 = 45'h0fedcba98765, all channels, pulse relu_enable -> 4608 writes; rows 0-11 write 0, rows 12-23 write 45'h0fedcba98765; relu_done=1 4611 cycles after start.
REQ-035 Hold relu_hold=1 for 10 cycles at element 100 -> exactly 2 writes during the hold (elements 98, 99), no reads; resumes at element 100; total latency 4621 cycles.
REQ-036 Pulse relu_enable during RUN -> no restart; read count stays 4608.
REQ-037 Assert rst at element 2000 -> all outputs 0 within the reset cycle, no further writes; a new start reads (0,0,0) first.
REQ-038 Boundary values: element 0 = 45'h100000000000 (min negative) -> 0; element 1 = 45'h0fffffffffff (max positive) -> passed unchanged; element 2 = 0 -> 0.
REQ-039 Start from DONE -> relu_done falls on the start edge and a second identical pass completes.

Source files
------------

// File: rtl/relu_ctrl.sv
// relu_ctrl: streams every element of CHANNELS maps (MAP_X rows x MAP_Y cols)
// from the convolution buffer, applies ReLU and writes it to the result buffer.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   relu_enable          start one full pass (from IDLE or DONE)
//   relu_hold            pause issue of new reads (in-flight elements finish)
//   rd_en, rd_ch/row/col read strobe and address; rd_data returns one cycle later
//   wr_en, wr_ch/row/col write strobe and address, wr_data = ReLU(rd_data)
//   busy                 high while in RUN or DRAIN
//   relu_done            high while in DONE
module relu_ctrl #(
   parameter int unsigned DATA_WIDTH = 45,
   parameter int unsigned MAP_X      = 24,
   parameter int unsigned MAP_Y      = 24,
   parameter int unsigned CHANNELS   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  relu_enable,
   input  logic                  relu_hold,
   output logic                  rd_en,
   output logic [2:0]            rd_ch,
   output logic [4:0]            rd_row,
   output logic [4:0]            rd_col,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wr_en,
   output logic [2:0]            wr_ch,
   output logic [4:0]            wr_row,
   output logic [4:0]            wr_col,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  relu_done
);

   localparam int unsigned CH_W  = 3;
   localparam int unsigned ROW_W = 5;
   localparam int unsigned COL_W = 5;

   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_X - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_Y - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
   logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
   logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
   logic                  all_issued_q, all_issued_d;
   logic                  drain_cnt_q, drain_cnt_d;
   logic                  rd_en_q, rd_en_d;
   logic [CH_W-1:0]       rd_ch_q, rd_ch_d;
   logic [ROW_W-1:0]      rd_row_q, rd_row_d;
   logic [COL_W-1:0]      rd_col_q, rd_col_d;
   logic                  p1_vld_q, p1_vld_d;
   logic [CH_W-1:0]       p1_ch_q, p1_ch_d;
   logic [ROW_W-1:0]      p1_row_q, p1_row_d;
   logic [COL_W-1:0]      p1_col_q, p1_col_d;
   logic                  wr_en_q, wr_en_d;
   logic [CH_W-1:0]       wr_ch_q, wr_ch_d;
   logic [ROW_W-1:0]      wr_row_q, wr_row_d;
   logic [COL_W-1:0]      wr_col_q, wr_col_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  busy_q, busy_d;
   logic                  relu_done_q, relu_done_d;

   // Next-state, address issue and pipeline logic
   always_comb begin
      state_d      = state_q;
      ch_cnt_d     = ch_cnt_q;
      row_cnt_d    = row_cnt_q;
      col_cnt_d    = col_cnt_q;
      all_issued_d = all_issued_q;
      drain_cnt_d  = drain_cnt_q;
      rd_en_d      = 1'b0;
      rd_ch_d      = rd_ch_q;
      rd_row_d     = rd_row_q;
      rd_col_d     = rd_col_q;

      // Stage 1 tracks the read issued last cycle; its data arrives now
      p1_vld_d = rd_en_q;
      p1_ch_d  = rd_ch_q;
      p1_row_d = rd_row_q;
      p1_col_d = rd_col_q;

      // Stage 2 registers the write; idle outputs are forced to zero
      wr_en_d   = p1_vld_q;
      wr_ch_d   = p1_vld_q ? p1_ch_q  : '0;
      wr_row_d  = p1_vld_q ? p1_row_q : '0;
      wr_col_d  = p1_vld_q ? p1_col_q : '0;
      wr_data_d = (p1_vld_q && !rd_data[DATA_WIDTH-1]) ? rd_data : '0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (relu_enable) begin
               state_d      = S_RUN;
               all_issued_d = 1'b0;
            end
         end
         S_RUN: begin
            // Leave RUN the cycle after the last read is on the bus
            if (all_issued_q) begin
               state_d     = S_DRAIN;
               drain_cnt_d = 1'b0;
            end else if (!relu_hold) begin
               rd_en_d  = 1'b1;
               rd_ch_d  = ch_cnt_q;
               rd_row_d = row_cnt_q;
               rd_col_d = col_cnt_q;
               // col fastest, then row, then channel; full wrap leaves counters at 0
               if (col_cnt_q == COL_LAST) begin
                  col_cnt_d = '0;
                  if (row_cnt_q == ROW_LAST) begin
                     row_cnt_d = '0;
                     if (ch_cnt_q == CH_LAST) begin
                        ch_cnt_d     = '0;
                        all_issued_d = 1'b1;
                     end else begin
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                     end
                  end else begin
                     row_cnt_d = row_cnt_q + ROW_W'(1);
                  end
               end else begin
                  col_cnt_d = col_cnt_q + COL_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q) state_d = S_DONE;
            else             drain_cnt_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d      = (state_d == S_RUN) || (state_d == S_DRAIN);
      relu_done_d = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ch_cnt_q     <= '0;
         row_cnt_q    <= '0;
         col_cnt_q    <= '0;
         all_issued_q <= 1'b0;
         drain_cnt_q  <= 1'b0;
         rd_en_q      <= 1'b0;
         rd_ch_q      <= '0;
         rd_row_q     <= '0;
         rd_col_q     <= '0;
         p1_vld_q     <= 1'b0;
         p1_ch_q      <= '0;
         p1_row_q     <= '0;
         p1_col_q     <= '0;
         wr_en_q      <= 1'b0;
         wr_ch_q      <= '0;
         wr_row_q     <= '0;
         wr_col_q     <= '0;
         wr_data_q    <= '0;
         busy_q       <= 1'b0;
         relu_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_cnt_q     <= ch_cnt_d;
         row_cnt_q    <= row_cnt_d;
         col_cnt_q    <= col_cnt_d;
         all_issued_q <= all_issued_d;
         drain_cnt_q  <= drain_cnt_d;
         rd_en_q      <= rd_en_d;
         rd_ch_q      <= rd_ch_d;
         rd_row_q     <= rd_row_d;
         rd_col_q     <= rd_col_d;
         p1_vld_q     <= p1_vld_d;
         p1_ch_q      <= p1_ch_d;
         p1_row_q     <= p1_row_d;
         p1_col_q     <= p1_col_d;
         wr_en_q      <= wr_en_d;
         wr_ch_q      <= wr_ch_d;
         wr_row_q     <= wr_row_d;
         wr_col_q     <= wr_col_d;
         wr_data_q    <= wr_data_d;
         busy_q       <= busy_d;
         relu_done_q  <= relu_done_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_ch     = rd_ch_q;
   assign rd_row    = rd_row_q;
   assign rd_col    = rd_col_q;
   assign wr_en     = wr_en_q;
   assign wr_ch     = wr_ch_q;
   assign wr_row    = wr_row_q;
   assign wr_col    = wr_col_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign relu_done = relu_done_q;

endmodule

// File: tb/tb_relu_ctrl.sv
// Bench for relu_ctrl: buffer model, stream monitor against an index-based
// reference (element k -> address and ReLU of stored value), scenario tasks.
module tb_relu_ctrl;

   localparam int unsigned DW  = 45;
   localparam int          NX  = 24;
   localparam int          NY  = 24;
   localparam int          NC  = 8;
   localparam int          NEL = NC * NX * NY;
   localparam int          LAT = NEL + 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          relu_enable = 1'b0;
   logic          relu_hold = 1'b0;
   logic          rd_en;
   logic [2:0]    rd_ch;
   logic [4:0]    rd_row;
   logic [4:0]    rd_col;
   logic [DW-1:0] rd_data = '0;
   logic          wr_en;
   logic [2:0]    wr_ch;
   logic [4:0]    wr_row;
   logic [4:0]    wr_col;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          relu_done;

   relu_ctrl #(.DATA_WIDTH(DW), .MAP_X(NX), .MAP_Y(NY), .CHANNELS(NC)) dut (
      .clk(clk), .rst(rst), .relu_enable(relu_enable), .relu_hold(relu_hold),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(rd_data), .wr_en(wr_en), .wr_ch(wr_ch), .wr_row(wr_row),
      .wr_col(wr_col), .wr_data(wr_data), .busy(busy), .relu_done(relu_done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [NEL];
   logic [DW-1:0] cap [3];
   int cyc = 0;
   int rd_cnt = 0, wr_cnt = 0, rd_err = 0, wr_err = 0;
   int rd_base = 0, wr_base = 0;
   int n_checks = 0, n_fail = 0;
   int mk, widx, bidx;

   function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
      return x[DW-1] ? '0 : x;
   endfunction

   function automatic logic [12:0] addr_of(input int k);
      logic [12:0] a;
      a = {3'(k / (NX * NY)), 5'((k / NY) % NX), 5'(k % NY)};
      return a;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Convolution buffer: data valid the cycle after rd_en
   always @(posedge clk) begin
      bidx = int'(rd_ch) * NX * NY + int'(rd_row) * NY + int'(rd_col);
      if (rd_en && bidx < NEL) rd_data <= mem[bidx];
      else                      rd_data <= 45'h05a5a5a5a5a;
   end

   // Stream monitor: k-th read/write of a pass must be element k
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en) begin
            mk = rd_cnt - rd_base;
            if (mk >= NEL || {rd_ch, rd_row, rd_col} != addr_of(mk)) rd_err++;
            rd_cnt++;
         end
         if (wr_en) begin
            widx = wr_cnt - wr_base;
            if (widx >= NEL) wr_err++;
            else if ({wr_ch, wr_row, wr_col} != addr_of(widx) || wr_data !== relu_ref(mem[widx])) wr_err++;
            if (widx >= 0 && widx < 3) cap[widx] = wr_data;
            wr_cnt++;
         end
      end
   end

   task automatic fill_random();
      for (int i = 0; i < NEL; i++) mem[i] = DW'({$urandom(), $urandom()});
   endtask

   task automatic start_pass(output int t0);
      @(negedge clk);
      rd_base = rd_cnt;
      wr_base = wr_cnt;
      relu_enable = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      relu_enable = 1'b0;
   endtask

   task automatic wait_done(input int t0, output int lat);
      lat = -1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (relu_done) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({rd_en, wr_en, busy, relu_done} !== 4'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {rd_en, wr_en, busy, relu_done});
      end
      n_checks++;
      if ({rd_ch, rd_row, rd_col, wr_ch, wr_row, wr_col} !== 26'b0) begin
         n_fail++; $display("FAIL reset_addr: got %h expected 0", {rd_ch, rd_row, rd_col, wr_ch, wr_row, wr_col});
      end
      n_checks++;
      if (wr_data !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0", wr_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_pattern();
      int t0, lat, e0;
      for (int i = 0; i < NEL; i++) mem[i] = (((i / NY) % NX) < 12) ? 45'h1fedcba98765 : 45'h0fedcba98765;
      e0 = rd_err + wr_err;
      start_pass(t0);
      wait_done(t0, lat);
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL pattern_latency: got %0d expected %0d", lat, LAT); end
      n_checks++;
      if (rd_cnt - rd_base != NEL) begin n_fail++; $display("FAIL pattern_reads: got %0d expected %0d", rd_cnt - rd_base, NEL); end
      n_checks++;
      if (wr_cnt - wr_base != NEL) begin n_fail++; $display("FAIL pattern_writes: got %0d expected %0d", wr_cnt - wr_base, NEL); end
      n_checks++;
      if (rd_err + wr_err != e0) begin n_fail++; $display("FAIL pattern_stream: got %0d bad elements expected 0", rd_err + wr_err - e0); end
   endtask

   task automatic test_boundary();
      int t0, lat, e0;
      fill_random();
      mem[0] = 45'h100000000000;
      mem[1] = 45'h0fffffffffff;
      mem[2] = '0;
      e0 = rd_err + wr_err;
      start_pass(t0);
      wait_done(t0, lat);
      n_checks++;
      if (cap[0] !== 45'h0) begin n_fail++; $display("FAIL bound_min_neg: got %h expected 0", cap[0]); end
      n_checks++;
      if (cap[1] !== 45'h0fffffffffff) begin n_fail++; $display("FAIL bound_max_pos: got %h expected 0fffffffffff", cap[1]); end
      n_checks++;
      if (cap[2] !== 45'h0) begin n_fail++; $display("FAIL bound_zero: got %h expected 0", cap[2]); end
      n_checks++;
      if (lat != LAT || rd_err + wr_err != e0) begin
         n_fail++; $display("FAIL bound_pass: latency %0d bad %0d expected %0d and 0", lat, rd_err + wr_err - e0, LAT);
      end
   endtask

   task automatic test_random();
      int t0, lat, e0;
      fill_random();
      e0 = rd_err + wr_err;
      start_pass(t0);
      wait_done(t0, lat);
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL random_latency: got %0d expected %0d", lat, LAT); end
      n_checks++;
      if (wr_cnt - wr_base != NEL || rd_err + wr_err != e0) begin
         n_fail++; $display("FAIL random_stream: writes %0d bad %0d expected %0d and 0", wr_cnt - wr_base, rd_err + wr_err - e0, NEL);
      end
   endtask

   task automatic test_hold();
      int t0, lat, e0, hold_wr, hold_rd;
      logic found;
      fill_random();
      e0 = rd_err + wr_err;
      start_pass(t0);
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rd_en && {rd_ch, rd_row, rd_col} == addr_of(99)) begin found = 1'b1; break; end
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL hold_find: element 99 read not seen within 500 cycles"); end
      relu_hold = 1'b1;
      hold_wr = 0;
      hold_rd = 0;
      repeat (10) begin
         @(negedge clk);
         if (rd_en) hold_rd++;
         if (wr_en) hold_wr++;
      end
      relu_hold = 1'b0;
      n_checks++;
      if (hold_rd != 0) begin n_fail++; $display("FAIL hold_reads: got %0d expected 0", hold_rd); end
      n_checks++;
      if (hold_wr != 2) begin n_fail++; $display("FAIL hold_writes: got %0d expected 2", hold_wr); end
      @(negedge clk);
      n_checks++;
      if (!(rd_en && {rd_ch, rd_row, rd_col} == addr_of(100))) begin
         n_fail++; $display("FAIL hold_resume: got rd_en %b addr %h expected 1 and %h", rd_en, {rd_ch, rd_row, rd_col}, addr_of(100));
      end
      wait_done(t0, lat);
      n_checks++;
      if (lat != LAT + 10) begin n_fail++; $display("FAIL hold_latency: got %0d expected %0d", lat, LAT + 10); end
      n_checks++;
      if (rd_err + wr_err != e0) begin n_fail++; $display("FAIL hold_stream: got %0d bad elements expected 0", rd_err + wr_err - e0); end
   endtask

   task automatic test_enable_in_run();
      int t0, lat;
      fill_random();
      start_pass(t0);
      repeat (300) @(negedge clk);
      relu_enable = 1'b1;
      @(negedge clk);
      relu_enable = 1'b0;
      repeat (4300) @(negedge clk);
      relu_enable = 1'b1;
      @(negedge clk);
      relu_enable = 1'b0;
      wait_done(t0, lat);
      n_checks++;
      if (rd_cnt - rd_base != NEL) begin n_fail++; $display("FAIL enable_run_reads: got %0d expected %0d", rd_cnt - rd_base, NEL); end
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL enable_run_latency: got %0d expected %0d", lat, LAT); end
   endtask

   task automatic test_done_restart();
      int t0, lat, e0;
      @(negedge clk);
      n_checks++;
      if (relu_done !== 1'b1) begin n_fail++; $display("FAIL done_hold: got %b expected 1", relu_done); end
      e0 = rd_err + wr_err;
      start_pass(t0);
      n_checks++;
      if ({relu_done, busy} !== 2'b01) begin n_fail++; $display("FAIL done_restart_edge: got done,busy=%b expected 01", {relu_done, busy}); end
      wait_done(t0, lat);
      n_checks++;
      if (lat != LAT || rd_err + wr_err != e0 || wr_cnt - wr_base != NEL) begin
         n_fail++; $display("FAIL done_second_pass: latency %0d writes %0d bad %0d expected %0d %0d 0", lat, wr_cnt - wr_base, rd_err + wr_err - e0, LAT, NEL);
      end
   endtask

   task automatic test_reset_mid();
      int t0, lat, e0, w0;
      logic found;
      fill_random();
      start_pass(t0);
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rd_en && {rd_ch, rd_row, rd_col} == addr_of(2000)) begin found = 1'b1; break; end
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL rstmid_find: element 2000 read not seen"); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({rd_en, wr_en, busy, relu_done} !== 4'b0 || wr_data !== '0) begin
         n_fail++; $display("FAIL rstmid_outputs: got ctrl %b data %h expected 0000 and 0", {rd_en, wr_en, busy, relu_done}, wr_data);
      end
      @(negedge clk);
      rst = 1'b0;
      w0 = wr_cnt;
      repeat (10) @(negedge clk);
      n_checks++;
      if (wr_cnt != w0) begin n_fail++; $display("FAIL rstmid_no_writes: got %0d writes expected 0", wr_cnt - w0); end
      e0 = rd_err + wr_err;
      start_pass(t0);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (!(rd_en && {rd_ch, rd_row, rd_col} == 13'b0)) begin
         n_fail++; $display("FAIL rstmid_restart_addr: got rd_en %b addr %h expected 1 and 0", rd_en, {rd_ch, rd_row, rd_col});
      end
      wait_done(t0, lat);
      n_checks++;
      if (lat != LAT || rd_err + wr_err != e0) begin
         n_fail++; $display("FAIL rstmid_pass: latency %0d bad %0d expected %0d and 0", lat, rd_err + wr_err - e0, LAT);
      end
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_boundary();
      test_random();
      test_hold();
      test_enable_in_run();
      test_done_restart();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
